// File: rtl/hazard_pkg.sv
// Shared types and limits for the scoreboard hazard unit.
package hazard_pkg;

    typedef enum logic {HZ_IDLE, HZ_FLUSH} hz_state_e;

    localparam int MAX_LOAD_LAT     = 15;
    localparam int MAX_FLUSH_CYCLES = 7;
    localparam int FCNT_W           = $clog2(MAX_FLUSH_CYCLES + 1);

endpackage

// File: rtl/hz_sb_entry.sv
// One scoreboard slot: countdown of cycles until a loaded register is safe to read.
module hz_sb_entry
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic pending_o
);

    localparam int                CNT_W  = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A fresh load always restarts the countdown, even over a pending one.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pending_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit_sb.sv
// Scoreboard hazard unit: load-use stalls plus a redirect flush window.
// Optional saturating perf counters are enabled with the HAZARD_PERF_EN macro.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 3,
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    input  logic                  issue_mem_read_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    input  logic                  jal_en_i,
    input  logic                  jalr_en_i,
    input  logic                  branch_taken_i,
    output logic                  stall_o,
    output logic                  if_de_flush_o,
    output logic                  de_mw_flush_o,
    output logic                  busy_o,
    output logic [PERF_W-1:0]     stall_count_o,
    output logic [PERF_W-1:0]     flush_count_o
);

    localparam int                NUM_REGS     = 2 ** REG_ADDR_W;
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

    if (LOAD_LAT < 1 || LOAD_LAT > MAX_LOAD_LAT) begin : gLoadLatCheck
        $error("hazard_unit_sb: LOAD_LAT out of range 1..15");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > MAX_FLUSH_CYCLES) begin : gFlushCheck
        $error("hazard_unit_sb: FLUSH_CYCLES out of range 1..7");
    end

    logic [NUM_REGS-1:0] pending;
    logic                loadAccept;
    logic                rs1Hit;
    logic                rs2Hit;
    logic                hit;
    logic                redirect;
    logic                flushActive;
    hz_state_e           state_q;
    logic [FCNT_W-1:0]   fcnt_q;

    assign loadAccept = issue_valid_i && issue_mem_read_i && (issue_rd_addr_i != '0);

    assign pending[0] = 1'b0;
    for (genvar r = 1; r < NUM_REGS; r++) begin : gEntry
        hz_sb_entry #(
            .LOAD_LAT (LOAD_LAT)
        ) uEntry (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .load_i    (loadAccept && (issue_rd_addr_i == REG_ADDR_W'(r))),
            .pending_o (pending[r])
        );
    end

    // The bypass match on a same-cycle load makes the consumer wait the full LOAD_LAT.
    assign rs1Hit = rs1_used_i && (rs1_addr_i != '0) &&
                    (pending[rs1_addr_i] || (loadAccept && (rs1_addr_i == issue_rd_addr_i)));
    assign rs2Hit = rs2_used_i && (rs2_addr_i != '0) &&
                    (pending[rs2_addr_i] || (loadAccept && (rs2_addr_i == issue_rd_addr_i)));

    // Combinational paths are qualified by reset so every output reads 0 while held in reset.
    assign hit      = (rs1Hit || rs2Hit) && rst_ni;
    assign redirect = (jal_en_i || jalr_en_i || branch_taken_i) && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HZ_IDLE;
            fcnt_q  <= '0;
        end else if (redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state_q <= HZ_FLUSH;
                fcnt_q  <= FLUSH_RELOAD;
            end else begin
                state_q <= HZ_IDLE;
                fcnt_q  <= '0;
            end
        end else if (state_q == HZ_FLUSH) begin
            if (fcnt_q <= FCNT_W'(1)) begin
                state_q <= HZ_IDLE;
                fcnt_q  <= '0;
            end else begin
                fcnt_q  <= fcnt_q - FCNT_W'(1);
            end
        end
    end

    // A stalled consumer on the wrong path is simply killed, so flush beats stall.
    assign flushActive   = redirect || (state_q == HZ_FLUSH);
    assign de_mw_flush_o = flushActive;
    assign stall_o       = hit && !flushActive;
    assign if_de_flush_o = stall_o;
    assign busy_o        = |pending;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stallCnt_q;
    logic [PERF_W-1:0] flushCnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (stall_o && !(&stallCnt_q)) begin
                stallCnt_q <= stallCnt_q + PERF_W'(1);
            end
            if (redirect && !(&flushCnt_q)) begin
                flushCnt_q <= flushCnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_count_o = stallCnt_q;
    assign flush_count_o = flushCnt_q;
`else
    assign stall_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Randomized and directed bench for hazard_unit_sb against a cycle-timestamp reference model.
module tb_hazard_unit_sb;

    localparam int REG_ADDR_W   = 3;
    localparam int LOAD_LAT     = 3;
    localparam int FLUSH_CYCLES = 3;
    localparam int PERF_W       = 4;
    localparam int NUM_REGS     = 2 ** REG_ADDR_W;
    localparam longint PERF_MAX = (64'd1 << PERF_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  issue_valid;
    logic                  issue_mem_read;
    logic [REG_ADDR_W-1:0] issue_rd_addr;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  jal_en;
    logic                  jalr_en;
    logic                  branch_taken;
    logic                  stall;
    logic                  if_de_flush;
    logic                  de_mw_flush;
    logic                  busy;
    logic [PERF_W-1:0]     stall_count;
    logic [PERF_W-1:0]     flush_count;

    hazard_unit_sb #(
        .REG_ADDR_W   (REG_ADDR_W),
        .LOAD_LAT     (LOAD_LAT),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .PERF_W       (PERF_W)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .issue_valid_i    (issue_valid),
        .issue_mem_read_i (issue_mem_read),
        .issue_rd_addr_i  (issue_rd_addr),
        .rs1_addr_i       (rs1_addr),
        .rs2_addr_i       (rs2_addr),
        .rs1_used_i       (rs1_used),
        .rs2_used_i       (rs2_used),
        .jal_en_i         (jal_en),
        .jalr_en_i        (jalr_en),
        .branch_taken_i   (branch_taken),
        .stall_o          (stall),
        .if_de_flush_o    (if_de_flush),
        .de_mw_flush_o    (de_mw_flush),
        .busy_o           (busy),
        .stall_count_o    (stall_count),
        .flush_count_o    (flush_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: each register remembers the first cycle at which it may be read again.
    longint readyAt [NUM_REGS];
    longint flushEnd;
    longint cyc;
    longint stallCntM;
    longint flushCntM;

    logic obsStall;
    logic obsFlush;
    int   stallsSeen;
    int   flushSeen;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic resetModel();
        for (int r = 0; r < NUM_REGS; r++) readyAt[r] = 0;
        flushEnd  = -1;
        cyc       = 0;
        stallCntM = 0;
        flushCntM = 0;
    endtask

    task automatic idleInputs();
        issue_valid    = 1'b0;
        issue_mem_read = 1'b0;
        issue_rd_addr  = '0;
        rs1_addr       = '0;
        rs2_addr       = '0;
        rs1_used       = 1'b0;
        rs2_used       = 1'b0;
        jal_en         = 1'b0;
        jalr_en        = 1'b0;
        branch_taken   = 1'b0;
    endtask

    task automatic applyStimulus();
        issue_valid    = ($urandom_range(0, 3) != 0);
        issue_mem_read = $urandom_range(0, 1) == 1;
        issue_rd_addr  = REG_ADDR_W'($urandom_range(0, NUM_REGS - 1));
        rs1_addr       = REG_ADDR_W'($urandom_range(0, NUM_REGS - 1));
        rs2_addr       = REG_ADDR_W'($urandom_range(0, NUM_REGS - 1));
        rs1_used       = $urandom_range(0, 1) == 1;
        rs2_used       = $urandom_range(0, 1) == 1;
        jal_en         = ($urandom_range(0, 23) == 0);
        jalr_en        = ($urandom_range(0, 23) == 0);
        branch_taken   = ($urandom_range(0, 15) == 0);
    endtask

    function automatic bit srcHit(input logic [REG_ADDR_W-1:0] a, input logic used, input bit accept);
        return used && (a != 0) && ((accept && (a == issue_rd_addr)) || (readyAt[a] > cyc));
    endfunction

    // Checks one cycle at the falling edge, then advances the model past the rising edge.
    task automatic stepAndCheck();
        bit accept;
        bit redirect;
        bit expFlush;
        bit expStall;
        bit expBusy;
        @(negedge clk);
        accept   = issue_valid && issue_mem_read && (issue_rd_addr != 0);
        redirect = jal_en || jalr_en || branch_taken;
        expFlush = redirect || (cyc <= flushEnd);
        expStall = (srcHit(rs1_addr, rs1_used, accept) || srcHit(rs2_addr, rs2_used, accept)) && !expFlush;
        expBusy  = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) if (readyAt[r] > cyc) expBusy = 1'b1;
        obsStall = stall;
        obsFlush = de_mw_flush;
        checkOutput("stall", 64'(stall), 64'(expStall));
        checkOutput("ifDeFlush", 64'(if_de_flush), 64'(expStall));
        checkOutput("deMwFlush", 64'(de_mw_flush), 64'(expFlush));
        checkOutput("busy", 64'(busy), 64'(expBusy));
        checkOutput("stallCount", 64'(stall_count), 64'(stallCntM));
        checkOutput("flushCount", 64'(flush_count), 64'(flushCntM));
        if (accept) readyAt[issue_rd_addr] = cyc + LOAD_LAT;
        if (redirect) flushEnd = cyc + FLUSH_CYCLES - 1;
`ifdef HAZARD_PERF_EN
        if (expStall && stallCntM < PERF_MAX) stallCntM++;
        if (redirect && flushCntM < PERF_MAX) flushCntM++;
`endif
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Stall"}, 64'(stall), 64'd0);
        checkOutput({tag, "IfDe"}, 64'(if_de_flush), 64'd0);
        checkOutput({tag, "DeMw"}, 64'(de_mw_flush), 64'd0);
        checkOutput({tag, "Busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "StallCnt"}, 64'(stall_count), 64'd0);
        checkOutput({tag, "FlushCnt"}, 64'(flush_count), 64'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        idleInputs();
        resetModel();
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Consumer directly behind a load stalls exactly LOAD_LAT cycles.
        stallsSeen = 0;
        issue_valid = 1'b1; issue_mem_read = 1'b1; issue_rd_addr = 3'd3;
        rs1_addr = 3'd3; rs1_used = 1'b1;
        stepAndCheck();
        stallsSeen += int'(obsStall);
        issue_valid = 1'b0;
        repeat (LOAD_LAT + 1) begin
            stepAndCheck();
            stallsSeen += int'(obsStall);
        end
        checkOutput("loadUseLen", 64'(stallsSeen), 64'(LOAD_LAT));

        // Back-to-back loads to the same register extend the stall by one.
        idleInputs();
        stallsSeen = 0;
        issue_valid = 1'b1; issue_mem_read = 1'b1; issue_rd_addr = 3'd5;
        rs2_addr = 3'd5; rs2_used = 1'b1;
        stepAndCheck();
        stallsSeen += int'(obsStall);
        stepAndCheck();
        stallsSeen += int'(obsStall);
        issue_valid = 1'b0;
        repeat (LOAD_LAT + 1) begin
            stepAndCheck();
            stallsSeen += int'(obsStall);
        end
        checkOutput("reloadLen", 64'(stallsSeen), 64'(LOAD_LAT + 1));

        // x0 loads and unused sources never stall.
        idleInputs();
        stallsSeen = 0;
        issue_valid = 1'b1; issue_mem_read = 1'b1; issue_rd_addr = 3'd0;
        rs1_addr = 3'd0; rs1_used = 1'b1;
        stepAndCheck();
        stallsSeen += int'(obsStall);
        issue_rd_addr = 3'd4; rs1_used = 1'b0;
        stepAndCheck();
        issue_valid = 1'b0; rs2_addr = 3'd4; rs2_used = 1'b0;
        repeat (3) begin
            stepAndCheck();
            stallsSeen += int'(obsStall);
        end
        checkOutput("noFalseStall", 64'(stallsSeen), 64'd0);

        // Redirect in the middle of an open window restarts it.
        idleInputs();
        repeat (LOAD_LAT) stepAndCheck();
        flushSeen = 0;
        jal_en = 1'b1;
        stepAndCheck();
        flushSeen += int'(obsFlush);
        jal_en = 1'b0; branch_taken = 1'b1;
        stepAndCheck();
        flushSeen += int'(obsFlush);
        branch_taken = 1'b0;
        repeat (4) begin
            stepAndCheck();
            flushSeen += int'(obsFlush);
        end
        checkOutput("flushLen", 64'(flushSeen), 64'(FLUSH_CYCLES + 1));

        // Flush beats a coincident load-use hit; the entry still drains.
        idleInputs();
        issue_valid = 1'b1; issue_mem_read = 1'b1; issue_rd_addr = 3'd2;
        rs1_addr = 3'd2; rs1_used = 1'b1; jalr_en = 1'b1;
        stepAndCheck();
        checkOutput("hitUnderFlushStall", 64'(obsStall), 64'd0);
        checkOutput("hitUnderFlushFlush", 64'(obsFlush), 64'd1);
        idleInputs();
        repeat (LOAD_LAT + 1) stepAndCheck();

        // Asynchronous reset in the middle of a stall and a flush.
        issue_valid = 1'b1; issue_mem_read = 1'b1; issue_rd_addr = 3'd6;
        rs1_addr = 3'd6; rs1_used = 1'b1;
        stepAndCheck();
        jal_en = 1'b1;
        stepAndCheck();
        jal_en = 1'b0; issue_valid = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        checkAllZero("midReset");
        idleInputs();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        resetModel();
        stepAndCheck();

        // Long continuous stall to drive the perf counter into saturation.
        issue_valid = 1'b1; issue_mem_read = 1'b1; issue_rd_addr = 3'd1;
        rs1_addr = 3'd1; rs1_used = 1'b1;
        repeat (int'(PERF_MAX) + 6) stepAndCheck();
`ifdef HAZARD_PERF_EN
        checkOutput("stallSat", 64'(stall_count), PERF_MAX);
`else
        checkOutput("stallCntTied", 64'(stall_count), 64'd0);
`endif
        idleInputs();

        repeat (400) begin
            applyStimulus();
            stepAndCheck();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Scoreboard-based hazard control unit for the riscv-mini pipeline.
- Tracks in-flight loads per architectural register with countdown timers and stalls decode for exactly the remaining load latency.
- Holds a flush window of configurable length after jal, jalr or a taken branch.
- Sits beside the DE/EX stage registers and drives pipeline-register stall and flush controls.

Parameters:
REG_ADDR_W, 3, register address width; NUM_REGS = 2**REG_ADDR_W
LOAD_LAT, 2, cycles a dependent consumer must stall behind a load; legal range 1..15 (elaboration assertion)
FLUSH_CYCLES, 1, cycles de_mw_flush_o stays high per redirect; legal range 1..7
PERF_W, 16, width of the performance counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  EX-stage instruction valid (the older instruction, entering scoreboard this cycle)
issue_mem_read_i  in  1  EX instruction is a load
issue_rd_addr_i  in  REG_ADDR_W  EX destination register
rs1_addr_i  in  REG_ADDR_W  DE-stage source 1
rs2_addr_i  in  REG_ADDR_W  DE-stage source 2
rs1_used_i  in  1  DE instruction reads rs1
rs2_used_i  in  1  DE instruction reads rs2
jal_en_i  in  1  jal resolved this cycle
jalr_en_i  in  1  jalr resolved this cycle
branch_taken_i  in  1  taken branch resolved this cycle
stall_o  out  1  hold PC and IF/DE register
if_de_flush_o  out  1  insert bubble into DE/EX
de_mw_flush_o  out  1  kill wrong-path instructions
busy_o  out  1  any scoreboard entry pending
stall_count_o  out  PERF_W  saturating stall-cycle count
flush_count_o  out  PERF_W  saturating redirect count

Behaviour:
Reset values:
- All counters = 0; FSM in HZ_IDLE.
- All outputs = 0.
- Reset asserted mid-operation discards pending loads and any open flush window immediately.

Scoreboard:
- Each register r has cnt[r], width $clog2(LOAD_LAT+1); pending[r] = (cnt[r] != 0).
- Load accept: when issue_valid_i && issue_mem_read_i && issue_rd_addr_i != 0, cnt[rd] <= LOAD_LAT-1 at the clock edge. Acceptance is not gated by stall_o.
- All other nonzero counters decrement by 1 each cycle.
- A new load to a register that is already pending reloads its counter; reload wins over decrement.
- Register 0 is never tracked.

Load-use hit (combinational):
- Hit when a used source (rsN_used_i && rsN_addr_i != 0) matches a pending register, OR matches issue_rd_addr_i of a load being accepted this cycle.
- Consequence: a consumer directly behind a load stalls exactly LOAD_LAT cycles and proceeds in cycle LOAD_LAT+1.

Redirect FSM:
- States: HZ_IDLE, HZ_FLUSH. Internal counter fcnt.
- redirect = jal_en_i | jalr_en_i | branch_taken_i.
- HZ_IDLE + redirect: de_mw_flush_o = 1 in that same cycle (combinational). If FLUSH_CYCLES > 1, go to HZ_FLUSH with fcnt = FLUSH_CYCLES-1.
- HZ_FLUSH: de_mw_flush_o = 1 and fcnt decrements; return to HZ_IDLE when fcnt reaches 1 at the edge.
- Redirect while in HZ_FLUSH restarts the window: fcnt = FLUSH_CYCLES-1.

Outputs and priority:
- stall_o = if_de_flush_o = hit && !de_mw_flush_o. A flush wins because the stalled consumer is wrong-path.
- Scoreboard still accepts and decrements during a flush.
- busy_o = OR of all pending bits (registered state only).

Optional Feature:
HAZARD_PERF_EN
- Defined: stall_count_o increments every cycle stall_o = 1. flush_count_o increments on each redirect input cycle. Both saturate at all-ones and clear only on reset.
- Undefined: both ports exist but are tied to 0, and no counter flops are synthesised.

Decomposition:
Package hazard_pkg:
- typedef enum logic {HZ_IDLE, HZ_FLUSH} hz_state_e.
- localparams MAX_LOAD_LAT = 15 and MAX_FLUSH_CYCLES = 7.
Sub-module hz_sb_entry (one per register via generate):
- Holds the countdown counter, load/reload logic and pending output.
- Top level does address match, FSM and perf counters.

Test Plan:
1. LOAD_LAT=2: load to x3 accepted at cycle 0; DE reads rs1=x3 from cycle 0 -> stall_o=1 in cycles 0 and 1, 0 in cycle 2; busy_o=1 in cycle 1 only.
2. LOAD_LAT=3, load to x5 at cycle 0, second load to x5 at cycle 1; consumer of x5 -> stall_o high in cycles 0..3, low in cycle 4 (reload).
3. Load to x0, or rs2_used_i=0 with rs2=x4 pending -> stall_o never asserts.
4. FLUSH_CYCLES=3: jal_en_i pulse at cycle 0 -> de_mw_flush_o high in cycles 0-2. Branch_taken pulse at cycle 1 -> flush extends through cycle 3.
5. Load-use hit coincident with jalr_en_i -> de_mw_flush_o=1, stall_o=0, if_de_flush_o=0. Scoreboard entry still clears on schedule.
6. Assert rst_ni low mid-stall and mid-flush -> all outputs 0 asynchronously. With HAZARD_PERF_EN, force 2**PERF_W stalls -> stall_count_o holds all-ones.
